frame_arbiter: RTL and testbench

Two-requester frame scheduler that sits in front of the 8b/10b encoder with CRC append and shares it between two byte-stream sources. It wraps each granted packet as SOF control symbol (K27.7), data symbols, then EOF control symbol (K28.5). K28.5 makes the encoder append CRC-32. The block enforces the encoder's CRC tail time and an inter-frame gap, arbitrates round-robin and truncates over-length frames.

---
 rtl/frame_arbiter.sv | 169 ++++++++++++++++
 tb/tb_frame_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_arbiter.sv
// Round-robin framer sharing one 8b/10b+CRC encoder between two byte sources (SOF, data, EOF, CRC tail, gap).
// Latency: valid->SOF 1 cycle, byte->datain 1 cycle; backpressure: symbol holds and ready drops while enc_ready is low.
module frame_arbiter #(
   parameter int MAX_LEN     = 64,
   parameter int TAIL_CYCLES = 6,
   parameter int IDLE_GAP    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   input  logic       enc_ready,
   output logic       pushin,
   output logic       startin,
   output logic [8:0] datain,
   output logic [1:0] grant,
   output logic       busy,
   output logic       err_len
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SOF,
      S_DATA,
      S_EOF_LOAD,
      S_EOF,
      S_TAIL,
      S_GAP
   } state_t;

   localparam logic [8:0] SOF_SYM   = 9'h1FB;
   localparam logic [8:0] EOF_SYM   = 9'h1BC;
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [7:0] TAIL_LAST = 8'(TAIL_CYCLES - 1);
   localparam logic [7:0] GAP_LAST  = 8'(IDLE_GAP - 1);
   localparam bit         NO_GAP    = (IDLE_GAP == 0);

   state_t     state;
   logic [7:0] count;
   logic [7:0] wait_cnt;
   logic       last_grant;

   logic       take_phase;
   logic       out_free;
   logic       consume;
   logic       accept;
   logic [7:0] sel_data;
   logic       sel_last;
   logic       len_hit;
   logic       any_vld;
   logic       pick1;
   logic       tail_done;
   logic       gap_done;
   logic       rearb;

   // Bytes are taken while SOF is still pending so a frame streams with no bubble after SOF.
   assign take_phase = (state == S_SOF) || (state == S_DATA);
   assign out_free   = !pushin || enc_ready;
   assign consume    = pushin && enc_ready;

   assign req0_ready = take_phase && grant[0] && out_free;
   assign req1_ready = take_phase && grant[1] && out_free;

   assign accept   = (req0_ready && req0_valid) || (req1_ready && req1_valid);
   assign sel_data = grant[1] ? req1_data : req0_data;
   assign sel_last = grant[1] ? req1_last : req0_last;
   assign len_hit  = (count + 8'd1) == MAX_LEN_B;

   assign any_vld = req0_valid || req1_valid;
   assign pick1   = req1_valid && (!req0_valid || !last_grant);

   // The final gap cycle doubles as the arbitration cycle, so the next SOF lands right after the gap.
   assign tail_done = (state == S_TAIL) && (wait_cnt == TAIL_LAST);
   assign gap_done  = (state == S_GAP) && (wait_cnt == GAP_LAST);
   assign rearb     = (state == S_IDLE) || gap_done || (tail_done && NO_GAP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         pushin     <= 1'b0;
         startin    <= 1'b0;
         datain     <= '0;
         grant      <= '0;
         busy       <= 1'b0;
         err_len    <= 1'b0;
         count      <= '0;
         wait_cnt   <= '0;
         last_grant <= 1'b1;
      end else begin
         err_len <= 1'b0;
         if (rearb) begin
            if (any_vld) begin
               grant      <= pick1 ? 2'b10 : 2'b01;
               last_grant <= pick1;
               datain     <= SOF_SYM;
               pushin     <= 1'b1;
               startin    <= 1'b1;
               count      <= '0;
               busy       <= 1'b1;
               state      <= S_SOF;
            end else begin
               grant <= '0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         end else begin
            case (state)
               S_SOF, S_DATA: begin
                  if (accept) begin
                     datain <= {1'b0, sel_data};
                     pushin <= 1'b1;
                     count  <= count + 8'd1;
                     if (sel_last || len_hit) begin
                        state <= S_EOF_LOAD;
                     end else begin
                        state <= S_DATA;
                     end
                     if (len_hit && !sel_last) begin
                        err_len <= 1'b1;
                     end
                  end else if (consume) begin
                     pushin <= 1'b0;
                     if (state == S_SOF) begin
                        count <= '0;
                        state <= S_DATA;
                     end
                  end
               end
               S_EOF_LOAD: begin
                  if (out_free) begin
                     datain <= EOF_SYM;
                     pushin <= 1'b1;
                     state  <= S_EOF;
                  end
               end
               S_EOF: begin
                  if (consume) begin
                     pushin   <= 1'b0;
                     startin  <= 1'b0;
                     wait_cnt <= '0;
                     state    <= S_TAIL;
                  end
               end
               S_TAIL: begin
                  if (tail_done) begin
                     wait_cnt <= '0;
                     state    <= S_GAP;
                  end else begin
                     wait_cnt <= wait_cnt + 8'd1;
                  end
               end
               S_GAP: begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_frame_arbiter.sv
// Directed bench for frame_arbiter: queue-fed requesters, symbol/cycle logging monitor, per-scenario checks.
module tb_frame_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req0_last, req0_ready;
   logic [7:0] req0_data;
   logic       req1_valid, req1_last, req1_ready;
   logic [7:0] req1_data;
   logic       enc_ready;
   logic       pushin, startin, busy, err_len;
   logic [8:0] datain;
   logic [1:0] grant;

   always #5 clk = ~clk;

   frame_arbiter #(.MAX_LEN(4), .TAIL_CYCLES(6), .IDLE_GAP(2)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
      .enc_ready(enc_ready), .pushin(pushin), .startin(startin), .datain(datain),
      .grant(grant), .busy(busy), .err_len(err_len)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [8:0] src0[$];
   logic [8:0] src1[$];
   bit         src_hold = 1'b0;

   logic [8:0] rx[$];
   int         rxc[$];
   logic [1:0] rxg[$];
   int         st_cnt, lb_cnt, err_cnt, vld_cyc, sof_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   // requester model: a queue of {last, data} per source, popped on handshake
   initial begin
      bit a0, a1;
      req0_valid = 0; req0_last = 0; req0_data = 0;
      req1_valid = 0; req1_last = 0; req1_data = 0;
      forever begin
         @(negedge clk);
         a0 = req0_valid && req0_ready && !reset;
         a1 = req1_valid && req1_ready && !reset;
         @(posedge clk);
         #1;
         if (a0 && src0.size() > 0) void'(src0.pop_front());
         if (a1 && src1.size() > 0) void'(src1.pop_front());
         if (src0.size() > 0 && !src_hold) begin
            req0_valid = 1; {req0_last, req0_data} = src0[0];
         end else begin
            req0_valid = 0; req0_last = 0; req0_data = 0;
         end
         if (src1.size() > 0 && !src_hold) begin
            req1_valid = 1; {req1_last, req1_data} = src1[0];
         end else begin
            req1_valid = 0; req1_last = 0; req1_data = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (pushin && enc_ready) begin
               rx.push_back(datain); rxc.push_back(cyc); rxg.push_back(grant);
            end
            if (startin) st_cnt++;
            if (busy && !pushin && !startin) lb_cnt++;
            if (err_len) err_cnt++;
            if (vld_cyc < 0 && (req0_valid || req1_valid)) vld_cyc = cyc;
            if (sof_cyc < 0 && pushin && datain == 9'h1FB) sof_cyc = cyc;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_log();
      rx.delete(); rxc.delete(); rxg.delete();
      st_cnt = 0; lb_cnt = 0; err_cnt = 0; vld_cyc = -1; sof_cyc = -1;
   endtask

   task automatic wait_done(input int lim, output bit ok);
      ok = 0;
      for (int i = 0; i < lim; i++) begin
         tick();
         if (src0.size() == 0 && src1.size() == 0 && !req0_valid && !req1_valid && !busy) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1; enc_ready = 1;
      repeat (2) tick();
      reset = 0;
      tick();
      checks++; if (pushin !== 1'b0) begin errors++; $display("FAIL rst_pushin: got %b want 0", pushin); end
      checks++; if (startin !== 1'b0) begin errors++; $display("FAIL rst_startin: got %b want 0", startin); end
      checks++; if (datain !== 9'h000) begin errors++; $display("FAIL rst_datain: got %h want 000", datain); end
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL rst_err_len: got %b want 0", err_len); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", {req0_ready, req1_ready}); end
   endtask

   task automatic test_single();
      bit ok;
      logic [8:0] exp[$];
      exp = '{9'h1FB, 9'h011, 9'h022, 9'h033, 9'h1BC};
      clear_log();
      src0.push_back({1'b0, 8'h11}); src0.push_back({1'b0, 8'h22}); src0.push_back({1'b1, 8'h33});
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_timeout: busy=%b want idle", busy); end
      checks++; if (rx.size() != exp.size()) begin errors++; $display("FAIL single_len: got %0d want %0d", rx.size(), exp.size()); end
      for (int i = 0; i < rx.size() && i < exp.size(); i++) begin
         checks++; if (rx[i] !== exp[i]) begin errors++; $display("FAIL single_sym%0d: got %h want %h", i, rx[i], exp[i]); end
      end
      if (rx.size() == 5) begin
         checks++; if (rxc[4] - rxc[0] != 4) begin errors++; $display("FAIL single_consecutive: span %0d want 4", rxc[4] - rxc[0]); end
         checks++; if (rxg[0] !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", rxg[0]); end
      end
      checks++; if (st_cnt != 5) begin errors++; $display("FAIL single_startin: got %0d cycles want 5", st_cnt); end
      checks++; if (lb_cnt != 8) begin errors++; $display("FAIL single_tail_gap: got %0d low cycles want 8", lb_cnt); end
      checks++; if (sof_cyc - vld_cyc != 1) begin errors++; $display("FAIL single_sof_latency: got %0d want 1", sof_cyc - vld_cyc); end
   endtask

   task automatic test_tie();
      bit ok;
      logic [8:0] exp[$];
      exp = '{9'h1FB, 9'h041, 9'h042, 9'h1BC, 9'h1FB, 9'h051, 9'h1BC,
              9'h1FB, 9'h043, 9'h044, 9'h1BC, 9'h1FB, 9'h052, 9'h1BC};
      reset = 1; tick(); reset = 0;
      clear_log();
      src0.push_back({1'b0, 8'h41}); src0.push_back({1'b1, 8'h42});
      src0.push_back({1'b0, 8'h43}); src0.push_back({1'b1, 8'h44});
      src1.push_back({1'b1, 8'h51}); src1.push_back({1'b1, 8'h52});
      wait_done(400, ok);
      checks++; if (!ok) begin errors++; $display("FAIL tie_timeout: busy=%b want idle", busy); end
      checks++; if (rx.size() != exp.size()) begin errors++; $display("FAIL tie_len: got %0d want %0d", rx.size(), exp.size()); end
      for (int i = 0; i < rx.size() && i < exp.size(); i++) begin
         checks++; if (rx[i] !== exp[i]) begin errors++; $display("FAIL tie_sym%0d: got %h want %h", i, rx[i], exp[i]); end
      end
      if (rx.size() == 14) begin
         checks++; if ({rxg[0], rxg[4], rxg[7], rxg[11]} !== 8'b01_10_01_10) begin errors++;
            $display("FAIL tie_grants: got %b %b %b %b want 01 10 01 10", rxg[0], rxg[4], rxg[7], rxg[11]); end
         checks++; if (rxc[4] - rxc[3] != 9) begin errors++; $display("FAIL tie_gap1: EOF->SOF %0d want 9", rxc[4] - rxc[3]); end
         checks++; if (rxc[7] - rxc[6] != 9) begin errors++; $display("FAIL tie_gap2: EOF->SOF %0d want 9", rxc[7] - rxc[6]); end
      end
   endtask

   task automatic test_backpressure();
      bit ok, found;
      logic [8:0] exp[$];
      exp = '{9'h1FB, 9'h011, 9'h022, 9'h033, 9'h1BC};
      clear_log();
      src0.push_back({1'b0, 8'h11}); src0.push_back({1'b0, 8'h22}); src0.push_back({1'b1, 8'h33});
      found = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (pushin && datain == 9'h022) begin found = 1; break; end
      end
      checks++; if (!found) begin errors++; $display("FAIL bp_reach: datain %h never showed 022", datain); end
      enc_ready = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (datain !== 9'h022 || pushin !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got %b/%h want 1/022", k, pushin, datain); end
         checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b want 0", k, req0_ready); end
      end
      enc_ready = 1;
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: busy=%b want idle", busy); end
      checks++; if (rx.size() != exp.size()) begin errors++; $display("FAIL bp_len: got %0d want %0d", rx.size(), exp.size()); end
      for (int i = 0; i < rx.size() && i < exp.size(); i++) begin
         checks++; if (rx[i] !== exp[i]) begin errors++; $display("FAIL bp_sym%0d: got %h want %h", i, rx[i], exp[i]); end
      end
      checks++; if (st_cnt != 8) begin errors++; $display("FAIL bp_startin: got %0d cycles want 8", st_cnt); end
   endtask

   task automatic test_truncation();
      bit ok;
      logic [8:0] exp[$];
      exp = '{9'h1FB, 9'h061, 9'h062, 9'h063, 9'h064, 9'h1BC, 9'h1FB, 9'h065, 9'h066, 9'h1BC};
      clear_log();
      for (int b = 1; b <= 6; b++) src1.push_back({(b == 6), 8'(8'h60 + b)});
      wait_done(300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL trunc_timeout: busy=%b want idle", busy); end
      checks++; if (rx.size() != exp.size()) begin errors++; $display("FAIL trunc_len: got %0d want %0d", rx.size(), exp.size()); end
      for (int i = 0; i < rx.size() && i < exp.size(); i++) begin
         checks++; if (rx[i] !== exp[i]) begin errors++; $display("FAIL trunc_sym%0d: got %h want %h", i, rx[i], exp[i]); end
      end
      checks++; if (err_cnt != 1) begin errors++; $display("FAIL trunc_err_len: got %0d pulses want 1", err_cnt); end
      if (rx.size() == 10) begin
         checks++; if (rxg[0] !== 2'b10 || rxg[6] !== 2'b10) begin errors++; $display("FAIL trunc_grant: got %b %b want 10 10", rxg[0], rxg[6]); end
         checks++; if (rxc[6] - rxc[5] != 9) begin errors++; $display("FAIL trunc_gap: EOF->SOF %0d want 9", rxc[6] - rxc[5]); end
      end
   endtask

   task automatic test_bc_data();
      bit ok;
      logic [8:0] exp[$];
      exp = '{9'h1FB, 9'h011, 9'h0BC, 9'h033, 9'h1BC};
      clear_log();
      src0.push_back({1'b0, 8'h11}); src0.push_back({1'b0, 8'hBC}); src0.push_back({1'b1, 8'h33});
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bc_timeout: busy=%b want idle", busy); end
      checks++; if (rx.size() != exp.size()) begin errors++; $display("FAIL bc_len: got %0d want %0d", rx.size(), exp.size()); end
      for (int i = 0; i < rx.size() && i < exp.size(); i++) begin
         checks++; if (rx[i] !== exp[i]) begin errors++; $display("FAIL bc_sym%0d: got %h want %h", i, rx[i], exp[i]); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok, found;
      logic [8:0] exp[$];
      clear_log();
      src0.push_back({1'b0, 8'h71}); src0.push_back({1'b0, 8'h72});
      src0.push_back({1'b0, 8'h73}); src0.push_back({1'b1, 8'h74});
      found = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (pushin && datain == 9'h072) begin found = 1; break; end
      end
      checks++; if (!found) begin errors++; $display("FAIL rmid_reach: datain %h never showed 072", datain); end
      reset = 1; src_hold = 1;
      tick();
      reset = 0;
      src0.delete();
      checks++; if ({pushin, startin, grant, busy} !== 5'b0) begin errors++;
         $display("FAIL rmid_clear: pushin/startin/grant/busy got %b/%b/%b/%b want 0/0/00/0", pushin, startin, grant, busy); end
      exp = '{9'h1FB, 9'h071};
      checks++; if (rx.size() != 2) begin errors++; $display("FAIL rmid_pre_len: got %0d want 2", rx.size()); end
      for (int i = 0; i < rx.size() && i < exp.size(); i++) begin
         checks++; if (rx[i] !== exp[i]) begin errors++; $display("FAIL rmid_pre_sym%0d: got %h want %h", i, rx[i], exp[i]); end
      end
      clear_log();
      repeat (6) tick();
      checks++; if (rx.size() != 0 || st_cnt != 0) begin errors++; $display("FAIL rmid_quiet: got %0d symbols %0d startin want 0 0", rx.size(), st_cnt); end
      src_hold = 0;
      src0.push_back({1'b1, 8'h81});
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout: busy=%b want idle", busy); end
      exp = '{9'h1FB, 9'h081, 9'h1BC};
      checks++; if (rx.size() != exp.size()) begin errors++; $display("FAIL rmid_post_len: got %0d want %0d", rx.size(), exp.size()); end
      for (int i = 0; i < rx.size() && i < exp.size(); i++) begin
         checks++; if (rx[i] !== exp[i]) begin errors++; $display("FAIL rmid_post_sym%0d: got %h want %h", i, rx[i], exp[i]); end
      end
   endtask

   initial begin
      reset = 1;
      enc_ready = 1;
      test_reset();
      test_tie();
      test_single();
      test_backpressure();
      test_truncation();
      test_bc_data();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
